// File: rtl/ps2_pkg.sv
// Shared PS/2 Set-2 byte constants and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [7:0] SC_CAPS    = 8'h58;
  localparam logic [7:0] SC_NUM     = 8'h77;
  localparam logic [7:0] SC_SCROLL  = 8'h7E;

  localparam logic [7:0] CMD_SET_LED = 8'hED;

  // Pause is E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    EXT     = 5'b00010,
    BRK     = 5'b00100,
    EXT_BRK = 5'b01000,
    SKIP    = 5'b10000
  } dec_state_e;

  function automatic logic is_reply(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_RESEND) ||
           (b == PS2_ECHO) || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_lock_tracker.sv
// Caps/Num/Scroll lock state with typematic suppression and the LED-update request handshake.
module ps2_lock_tracker
  import ps2_pkg::*;
(
  input  logic       clock_quarter,
  input  logic       reset,
  input  logic       evt_valid,
  input  logic [7:0] evt_code,
  input  logic       evt_ext,
  input  logic       evt_brk,
  input  logic       led_ack,
  output logic       caps_lock,
  output logic       num_lock,
  output logic       scroll_lock,
  output logic       led_req,
  output logic [2:0] led_byte
);

  // Bit order {caps, num, scroll} matches the LED byte layout.
  logic [2:0] hit;
  logic [2:0] held;
  logic [2:0] lock;
  logic [2:0] toggle;

  assign hit    = {evt_code == SC_CAPS, evt_code == SC_NUM, evt_code == SC_SCROLL}
                  & {3{evt_valid & ~evt_ext}};
  assign toggle = hit & ~held & {3{~evt_brk}};

  always_ff @(posedge clock_quarter or posedge reset) begin
    if (reset) begin
      held    <= '0;
      lock    <= '0;
      led_req <= 1'b0;
    end else begin
      held <= evt_brk ? (held & ~hit) : (held | hit);
      lock <= lock ^ toggle;
      if (|toggle)
        led_req <= 1'b1;
      else if (led_ack)
        led_req <= 1'b0;
    end
  end

  assign caps_lock   = lock[2];
  assign num_lock    = lock[1];
  assign scroll_lock = lock[0];
  assign led_byte    = lock;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 byte stream to key events and controller replies, with prefix timeout and lock tracking.
//   state   | meaning
//   IDLE    | no prefix pending; replies recognised here only
//   EXT     | E0 seen
//   BRK     | F0 seen
//   EXT_BRK | E0 F0 seen
//   SKIP    | swallowing the Pause sequence tail
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock_quarter,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_complete,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       ctrl_valid,
  output logic [7:0] ctrl_code,
  output logic       num_lock,
  output logic       caps_lock,
  output logic       scroll_lock,
  output logic       led_req,
  output logic [2:0] led_byte,
  input  logic       led_ack
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  dec_state_e       state, state_nxt;
  logic [2:0]       skip_cnt, skip_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             ev, ev_ext, ev_brk, cv;
  logic [7:0]       ev_code;

  always_ff @(posedge clock_quarter or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      tmo_cnt  <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    tmo_nxt   = '0;
    ev        = 1'b0;
    ev_code   = rx_data;
    ev_ext    = 1'b0;
    ev_brk    = 1'b0;
    cv        = 1'b0;
    if (rx_complete) begin
      case (state)
        IDLE: begin
          if (rx_data == PS2_EXT)
            state_nxt = EXT;
          else if (rx_data == PS2_BRK)
            state_nxt = BRK;
          else if (rx_data == PS2_PAUSE) begin
            state_nxt = SKIP;
            skip_nxt  = PAUSE_SKIP;
          end else if (is_reply(rx_data))
            cv = 1'b1;
          else
            ev = 1'b1;
        end
        EXT: begin
          if (rx_data == PS2_BRK)
            state_nxt = EXT_BRK;
          else if (rx_data != PS2_EXT) begin
            ev        = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          ev        = 1'b1;
          ev_brk    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          ev        = 1'b1;
          ev_ext    = 1'b1;
          ev_brk    = 1'b1;
          state_nxt = IDLE;
        end
        SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) begin
            ev        = 1'b1;
            ev_code   = PS2_PAUSE;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      // A stalled prefix is dropped silently.
      if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1))
        state_nxt = IDLE;
      else
        tmo_nxt = tmo_cnt + TMO_W'(1);
    end
  end

  always_ff @(posedge clock_quarter or posedge reset) begin
    if (reset) begin
      key_valid  <= 1'b0;
      key_code   <= '0;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl_code  <= '0;
    end else begin
      key_valid  <= ev;
      ctrl_valid <= cv;
      if (ev) begin
        key_code  <= ev_code;
        key_ext   <= ev_ext;
        key_break <= ev_brk;
      end
      if (cv)
        ctrl_code <= rx_data;
    end
  end

  // Fed from the unregistered event so lock changes line up with key_valid.
  ps2_lock_tracker u_lock (
    .clock_quarter (clock_quarter),
    .reset         (reset),
    .evt_valid     (ev),
    .evt_code      (ev_code),
    .evt_ext       (ev_ext),
    .evt_brk       (ev_brk),
    .led_ack       (led_ack),
    .caps_lock     (caps_lock),
    .num_lock      (num_lock),
    .scroll_lock   (scroll_lock),
    .led_req       (led_req),
    .led_byte      (led_byte)
  );

endmodule
